exc_sequencer: RTL and testbench
================================

Name: exc_sequencer

Overview:
- Multi-cycle controller behind the combinational exception prioritiser in the MEM stage.
- Takes the prioritised exception (flag, type, bad address, save flag), drains outstanding instruction and data bus transactions, then issues CP0 update pulses.
- Finally flushes the pipeline and redirects fetch to the handler vector, or to EPC/ErrorEPC on ERET.
- Owns stall/flush/redirect for all exceptions; no other block redirects on an exception.

Parameters:
- RST_VEC_BEV, 32'hBFC00200, vector base when Status.BEV=1
- RST_VEC_NRM, 32'h80000000, vector base when Status.BEV=0

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- exc_flag  in  1  an exception or ERET is present this cycle
- exc_type  in  5  prioritised type; ExcT_* encoding from shared package
- exc_save  in  1  faulting data reference was a store
- exc_baddr  in  32  bad virtual address
- exc_pc  in  32  PC of faulting instruction
- exc_bd  in  1  faulting instruction is in a delay slot
- ibus_busy  in  1  instruction bus has an outstanding transaction
- dbus_busy  in  1  data bus has an outstanding transaction
- cp0_Status  in  32  live Status
- cp0_Cause  in  32  live Cause
- cp0_EPC  in  32  live EPC
- cp0_ErrorEPC  in  32  live ErrorEPC
- seq_busy  out  1  sequencer not IDLE
- stall  out  1  hold all pipeline registers
- flush  out  1  kill all in-flight instructions
- redir_en  out  1  load redir_pc into PC
- redir_pc  out  32  redirect target
- cp0_exc_we  out  1  write Cause.ExcCode
- cp0_exc_code  out  5  ExcCode value
- cp0_epc_we  out  1  write EPC and Cause.BD
- cp0_epc  out  32  EPC value
- cp0_bd  out  1  Cause.BD value
- cp0_badv_we  out  1  write BadVAddr
- cp0_badv  out  32  BadVAddr value
- cp0_exl_set  out  1  set Status.EXL
- cp0_exl_clr  out  1  clear Status.EXL
- cp0_erl_clr  out  1  clear Status.ERL

Behaviour:
- Reset: state=IDLE; all registered outputs and capture registers cleared to 0. Asserting rst mid-sequence aborts immediately; no partial CP0 pulse is issued after reset.
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE:
  - When exc_flag=1, flush=1 combinationally in the same cycle (T), so the faulting and younger instructions never commit.
  - Capture type, baddr, pc, bd, save, Status.EXL, Status.BEV, Cause.IV.
  - Next state DRAIN.
- DRAIN:
  - stall=1, seq_busy=1.
  - Leave to COMMIT when ibus_busy=0 and dbus_busy=0, sampled the same cycle. Remain in DRAIN indefinitely otherwise.
- COMMIT: stall=1. One-cycle pulses:
  - Exception:
    - cp0_exc_we=1.
    - cp0_exc_code from the package map. TLBR/TLBI map to TLBL (2) or, if captured save=1, TLBS (3).
    - cp0_epc_we=1 only if captured EXL=0; cp0_epc=pc, cp0_bd=bd.
    - cp0_badv_we=1 for AdEL, AdES, TLBR, TLBI, TLBM.
    - cp0_exl_set=1.
  - ERET:
    - No ExcCode/EPC/BadVAddr write.
    - cp0_erl_clr=1 if live Status.ERL=1, else cp0_exl_clr=1.
    - redir target latched: ERL ? ErrorEPC : EPC.
- REDIRECT:
  - flush=1, redir_en=1, stall=0; next state IDLE.
  - Exception target = base + offset:
    - base = captured BEV ? RST_VEC_BEV : RST_VEC_NRM
    - offset 0x000 for TLBR with captured EXL=0
    - offset 0x180 otherwise
- Minimum latency: detect T, DRAIN T+1, COMMIT T+2, REDIRECT T+3, IDLE T+4.
- exc_flag is ignored outside IDLE. A back-to-back exception arriving at T+4 is accepted normally.
- seq_busy=1 in every state except IDLE.

Optional Feature:
- Macro EXC_SEQ_IV_EN.
- When defined: Intr with captured Cause.IV=1 (bit 23) and EXL=0 uses offset 0x200.
- When undefined: Cause.IV is not captured and Intr always uses offset 0x180.

Decomposition:
- Defines.v (shared): ExcT_* codes, ExcType width, MIPS ExcCode constants, vector offsets, Status/Cause bit-field macros (IE, EXL, ERL, BEV, IV).
- One sub-module, exc_vector_gen: combinational; captured type/EXL/BEV/IV -> ExcCode and handler address.

Test Plan:
- Syscall at pc=0x80001004, bd=0, BEV=0, EXL=0, buses idle -> flush at T; ExcCode=8, EPC=0x80001004, exl_set pulse at T+2; redir_pc=0x80000180 at T+3.
- TLBR store, baddr=0x00403000, EXL=0, dbus_busy high for 5 cycles -> DRAIN holds 5 cycles; ExcCode=3, BadVAddr=0x00403000; redir_pc=0x80000000.
- AdEL in delay slot, pc=0x80002008, EXL=1 -> no epc_we; badv_we=1; target 0x80000180.
- ERET with ERL=1, ErrorEPC=0xBFC00380 -> erl_clr pulse, no exl_clr; redir_pc=0xBFC00380.
- Intr, IV=1, BEV=1 -> 0xBFC00400 with EXC_SEQ_IV_EN defined; 0xBFC00380 without.
- rst asserted in DRAIN -> outputs 0 asynchronously; no COMMIT pulses follow; next exc_flag is handled normally.

Source files
------------

// File: rtl/exc_sequencer_pkg.sv
// Shared exception definitions: ExcT_* type encoding, MIPS ExcCode values,
// vector offsets, Status/Cause bit positions and sequencer state encoding.
package exc_sequencer_pkg;

   localparam int unsigned EXC_TYPE_W = 5;

   // Prioritiser output encoding; ERET travels on the same type bus.
   typedef enum logic [EXC_TYPE_W-1:0] {
      EXCT_INTR = 5'd0,
      EXCT_ADEL = 5'd1,
      EXCT_ADES = 5'd2,
      EXCT_IBE  = 5'd3,
      EXCT_DBE  = 5'd4,
      EXCT_SYS  = 5'd5,
      EXCT_BP   = 5'd6,
      EXCT_RI   = 5'd7,
      EXCT_CPU  = 5'd8,
      EXCT_OV   = 5'd9,
      EXCT_TRAP = 5'd10,
      EXCT_TLBR = 5'd11,
      EXCT_TLBI = 5'd12,
      EXCT_TLBM = 5'd13,
      EXCT_ERET = 5'd14
   } exc_type_e;

   localparam logic [4:0] EXC_CODE_INT  = 5'd0;
   localparam logic [4:0] EXC_CODE_MOD  = 5'd1;
   localparam logic [4:0] EXC_CODE_TLBL = 5'd2;
   localparam logic [4:0] EXC_CODE_TLBS = 5'd3;
   localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
   localparam logic [4:0] EXC_CODE_ADES = 5'd5;
   localparam logic [4:0] EXC_CODE_IBE  = 5'd6;
   localparam logic [4:0] EXC_CODE_DBE  = 5'd7;
   localparam logic [4:0] EXC_CODE_SYS  = 5'd8;
   localparam logic [4:0] EXC_CODE_BP   = 5'd9;
   localparam logic [4:0] EXC_CODE_RI   = 5'd10;
   localparam logic [4:0] EXC_CODE_CPU  = 5'd11;
   localparam logic [4:0] EXC_CODE_OV   = 5'd12;
   localparam logic [4:0] EXC_CODE_TR   = 5'd13;

   localparam logic [31:0] VEC_OFF_TLBR = 32'h0000_0000;
   localparam logic [31:0] VEC_OFF_GEN  = 32'h0000_0180;
   localparam logic [31:0] VEC_OFF_IV   = 32'h0000_0200;

   localparam int unsigned STATUS_IE  = 0;
   localparam int unsigned STATUS_EXL = 1;
   localparam int unsigned STATUS_ERL = 2;
   localparam int unsigned STATUS_BEV = 22;
   localparam int unsigned CAUSE_IV   = 23;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_COMMIT,
      ST_REDIRECT
   } seq_state_e;

   function automatic logic is_badv_type(input logic [EXC_TYPE_W-1:0] t);
      return (t == EXCT_ADEL) || (t == EXCT_ADES) || (t == EXCT_TLBR) ||
             (t == EXCT_TLBI) || (t == EXCT_TLBM);
   endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// Exception request from the prioritiser and CP0 update bundle.
// master = prioritiser/CP0 side, slave = exc_sequencer.
interface exc_sequencer_if;
   import exc_sequencer_pkg::*;

   logic                  exc_flag;
   logic [EXC_TYPE_W-1:0] exc_type;
   logic                  exc_save;
   logic [31:0]           exc_baddr;
   logic [31:0]           exc_pc;
   logic                  exc_bd;

   logic                  cp0_exc_we;
   logic [4:0]            cp0_exc_code;
   logic                  cp0_epc_we;
   logic [31:0]           cp0_epc;
   logic                  cp0_bd;
   logic                  cp0_badv_we;
   logic [31:0]           cp0_badv;
   logic                  cp0_exl_set;
   logic                  cp0_exl_clr;
   logic                  cp0_erl_clr;

   modport master (
      output exc_flag, exc_type, exc_save, exc_baddr, exc_pc, exc_bd,
      input  cp0_exc_we, cp0_exc_code, cp0_epc_we, cp0_epc, cp0_bd,
             cp0_badv_we, cp0_badv, cp0_exl_set, cp0_exl_clr, cp0_erl_clr
   );

   modport slave (
      input  exc_flag, exc_type, exc_save, exc_baddr, exc_pc, exc_bd,
      output cp0_exc_we, cp0_exc_code, cp0_epc_we, cp0_epc, cp0_bd,
             cp0_badv_we, cp0_badv, cp0_exl_set, cp0_exl_clr, cp0_erl_clr
   );

endinterface

// File: rtl/exc_sequencer_vector_gen.sv
// exc_vector_gen: combinational map from captured exception context to
// MIPS ExcCode, BadVAddr-write request and handler address.
module exc_vector_gen
   import exc_sequencer_pkg::*;
#(
   parameter logic [31:0] RST_VEC_BEV = 32'hBFC0_0200,
   parameter logic [31:0] RST_VEC_NRM = 32'h8000_0000
) (
   input  logic [EXC_TYPE_W-1:0] exc_type,
   input  logic                  save,
   input  logic                  exl,
   input  logic                  bev,
   input  logic                  iv,
   output logic [4:0]            exc_code,
   output logic                  badv_req,
   output logic [31:0]           vec_addr
);

   logic [31:0] offset;

   always_comb begin
      exc_code = EXC_CODE_RI;
      case (exc_type)
         EXCT_INTR: exc_code = EXC_CODE_INT;
         EXCT_ADEL: exc_code = EXC_CODE_ADEL;
         EXCT_ADES: exc_code = EXC_CODE_ADES;
         EXCT_IBE:  exc_code = EXC_CODE_IBE;
         EXCT_DBE:  exc_code = EXC_CODE_DBE;
         EXCT_SYS:  exc_code = EXC_CODE_SYS;
         EXCT_BP:   exc_code = EXC_CODE_BP;
         EXCT_RI:   exc_code = EXC_CODE_RI;
         EXCT_CPU:  exc_code = EXC_CODE_CPU;
         EXCT_OV:   exc_code = EXC_CODE_OV;
         EXCT_TRAP: exc_code = EXC_CODE_TR;
         EXCT_TLBR,
         EXCT_TLBI: exc_code = save ? EXC_CODE_TLBS : EXC_CODE_TLBL;
         EXCT_TLBM: exc_code = EXC_CODE_MOD;
         default:   exc_code = EXC_CODE_RI;
      endcase
   end

   // Refill gets the dedicated vector only when not already at exception level.
   always_comb begin
      offset = VEC_OFF_GEN;
      if ((exc_type == EXCT_TLBR) && !exl)
         offset = VEC_OFF_TLBR;
      else if ((exc_type == EXCT_INTR) && iv && !exl)
         offset = VEC_OFF_IV;
   end

   assign badv_req = is_badv_type(exc_type);
   assign vec_addr = (bev ? RST_VEC_BEV : RST_VEC_NRM) + offset;

endmodule

// File: rtl/exc_sequencer.sv
// Exception sequencer: flush on detect, drain buses, pulse CP0 updates, redirect.
// Optional macro EXC_SEQ_IV_EN enables the Cause.IV interrupt vector (offset 0x200).
module exc_sequencer
   import exc_sequencer_pkg::*;
#(
   parameter logic [31:0] RST_VEC_BEV = 32'hBFC0_0200,
   parameter logic [31:0] RST_VEC_NRM = 32'h8000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   exc_sequencer_if.slave        exc,
   input  logic                  ibus_busy,
   input  logic                  dbus_busy,
   input  logic [31:0]           cp0_Status,
   input  logic [31:0]           cp0_Cause,
   input  logic [31:0]           cp0_EPC,
   input  logic [31:0]           cp0_ErrorEPC,
   output logic                  seq_busy,
   output logic                  stall,
   output logic                  flush,
   output logic                  redir_en,
   output logic [31:0]           redir_pc
);

   seq_state_e            state_q, state_d;
   logic [EXC_TYPE_W-1:0] type_q;
   logic [31:0]           baddr_q, pc_q, redir_q;
   logic                  bd_q, save_q, exl_q, bev_q;
   logic                  iv_cap;
   logic                  capture, is_eret, live_erl;
   logic [4:0]            vec_code;
   logic                  vec_badv;
   logic [31:0]           vec_addr;
   logic                  unused_bits;

   assign capture  = (state_q == ST_IDLE) && exc.exc_flag;
   assign is_eret  = (type_q == EXCT_ERET);
   assign live_erl = cp0_Status[STATUS_ERL];

`ifdef EXC_SEQ_IV_EN
   logic iv_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         iv_q <= 1'b0;
      else if (capture)
         iv_q <= cp0_Cause[CAUSE_IV];
   end

   assign iv_cap      = iv_q;
   assign unused_bits = ^{cp0_Status[31:23], cp0_Status[21:3], cp0_Status[0],
                          cp0_Cause[31:24], cp0_Cause[22:0]};
`else
   assign iv_cap      = 1'b0;
   assign unused_bits = ^{cp0_Status[31:23], cp0_Status[21:3], cp0_Status[0],
                          cp0_Cause};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         type_q  <= '0;
         baddr_q <= '0;
         pc_q    <= '0;
         bd_q    <= 1'b0;
         save_q  <= 1'b0;
         exl_q   <= 1'b0;
         bev_q   <= 1'b0;
         redir_q <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            type_q  <= exc.exc_type;
            baddr_q <= exc.exc_baddr;
            pc_q    <= exc.exc_pc;
            bd_q    <= exc.exc_bd;
            save_q  <= exc.exc_save;
            exl_q   <= cp0_Status[STATUS_EXL];
            bev_q   <= cp0_Status[STATUS_BEV];
         end
         // ERET target uses live ERL at commit time, matching the clear pulse.
         if (state_q == ST_COMMIT)
            redir_q <= is_eret ? (live_erl ? cp0_ErrorEPC : cp0_EPC) : vec_addr;
      end
   end

   exc_vector_gen #(
      .RST_VEC_BEV (RST_VEC_BEV),
      .RST_VEC_NRM (RST_VEC_NRM)
   ) u_vector_gen (
      .exc_type (type_q),
      .save     (save_q),
      .exl      (exl_q),
      .bev      (bev_q),
      .iv       (iv_cap),
      .exc_code (vec_code),
      .badv_req (vec_badv),
      .vec_addr (vec_addr)
   );

   always_comb begin
      state_d         = state_q;
      seq_busy        = (state_q != ST_IDLE);
      stall           = 1'b0;
      flush           = 1'b0;
      redir_en        = 1'b0;
      exc.cp0_exc_we  = 1'b0;
      exc.cp0_epc_we  = 1'b0;
      exc.cp0_badv_we = 1'b0;
      exc.cp0_exl_set = 1'b0;
      exc.cp0_exl_clr = 1'b0;
      exc.cp0_erl_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (exc.exc_flag) begin
               flush   = 1'b1;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            stall = 1'b1;
            if (!ibus_busy && !dbus_busy)
               state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            stall   = 1'b1;
            state_d = ST_REDIRECT;
            if (is_eret) begin
               exc.cp0_erl_clr = live_erl;
               exc.cp0_exl_clr = !live_erl;
            end else begin
               exc.cp0_exc_we  = 1'b1;
               exc.cp0_epc_we  = !exl_q;
               exc.cp0_badv_we = vec_badv;
               exc.cp0_exl_set = 1'b1;
            end
         end
         ST_REDIRECT: begin
            flush    = 1'b1;
            redir_en = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign exc.cp0_exc_code = vec_code;
   assign exc.cp0_epc      = pc_q;
   assign exc.cp0_bd       = bd_q;
   assign exc.cp0_badv     = baddr_q;
   assign redir_pc         = redir_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: stimulus queues expected CP0 pulses and
// redirects; a negedge monitor pops and compares whenever the DUT emits them.
module tb_exc_sequencer;
   import exc_sequencer_pkg::*;

   typedef struct {
      int unsigned cyc;
      logic        exc_we;
      logic [4:0]  code;
      logic        epc_we;
      logic [31:0] epc;
      logic        bd;
      logic        badv_we;
      logic [31:0] badv;
      logic        exl_set;
      logic        exl_clr;
      logic        erl_clr;
   } commit_t;

   typedef struct {
      int unsigned cyc;
      logic [31:0] pc;
   } redir_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ibus_busy, dbus_busy;
   logic [31:0] cp0_Status, cp0_Cause, cp0_EPC, cp0_ErrorEPC;
   logic        seq_busy, stall, flush, redir_en;
   logic [31:0] redir_pc;

   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   commit_t     cq[$];
   redir_t      rq[$];
   commit_t     ce;
   redir_t      re;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   exc_sequencer_if bus ();

   exc_sequencer #(
      .RST_VEC_BEV (32'hBFC0_0200),
      .RST_VEC_NRM (32'h8000_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .exc          (bus),
      .ibus_busy    (ibus_busy),
      .dbus_busy    (dbus_busy),
      .cp0_Status   (cp0_Status),
      .cp0_Cause    (cp0_Cause),
      .cp0_EPC      (cp0_EPC),
      .cp0_ErrorEPC (cp0_ErrorEPC),
      .seq_busy     (seq_busy),
      .stall        (stall),
      .flush        (flush),
      .redir_en     (redir_en),
      .redir_pc     (redir_pc)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic commit_t mk(input logic exc_we, input logic [4:0] code,
                                  input logic epc_we, input logic [31:0] epc,
                                  input logic bd, input logic badv_we,
                                  input logic [31:0] badv, input logic exl_set,
                                  input logic exl_clr, input logic erl_clr);
      commit_t c;
      c.cyc = 0;
      c.exc_we = exc_we; c.code = code; c.epc_we = epc_we; c.epc = epc;
      c.bd = bd; c.badv_we = badv_we; c.badv = badv; c.exl_set = exl_set;
      c.exl_clr = exl_clr; c.erl_clr = erl_clr;
      return c;
   endfunction

   // Monitor: every CP0 pulse or redirect must match the head of its queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.cp0_exc_we | bus.cp0_epc_we | bus.cp0_badv_we |
             bus.cp0_exl_set | bus.cp0_exl_clr | bus.cp0_erl_clr) begin
            if (cq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_commit: got pulse at cycle %0d expected none", cyc);
            end else begin
               ce = cq.pop_front();
               chk("commit_cycle", 64'(cyc), 64'(ce.cyc));
               chk("exc_we", 64'(bus.cp0_exc_we), 64'(ce.exc_we));
               if (ce.exc_we) chk("exc_code", 64'(bus.cp0_exc_code), 64'(ce.code));
               chk("epc_we", 64'(bus.cp0_epc_we), 64'(ce.epc_we));
               if (ce.epc_we) begin
                  chk("epc", 64'(bus.cp0_epc), 64'(ce.epc));
                  chk("bd", 64'(bus.cp0_bd), 64'(ce.bd));
               end
               chk("badv_we", 64'(bus.cp0_badv_we), 64'(ce.badv_we));
               if (ce.badv_we) chk("badv", 64'(bus.cp0_badv), 64'(ce.badv));
               chk("exl_set", 64'(bus.cp0_exl_set), 64'(ce.exl_set));
               chk("exl_clr", 64'(bus.cp0_exl_clr), 64'(ce.exl_clr));
               chk("erl_clr", 64'(bus.cp0_erl_clr), 64'(ce.erl_clr));
            end
         end
         if (redir_en) begin
            if (rq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_redir: got redir_pc %h expected none", redir_pc);
            end else begin
               re = rq.pop_front();
               chk("redir_cycle", 64'(cyc), 64'(re.cyc));
               chk("redir_pc", 64'(redir_pc), 64'(re.pc));
               chk("redir_flush", 64'(flush), 64'd1);
               chk("redir_stall", 64'(stall), 64'd0);
            end
         end
      end
   end

   // Busy bus held high for n cycles starting at detect cycle T.
   task automatic send(input logic [4:0] t, input logic [31:0] pc, input logic [31:0] baddr,
                       input logic bd, input logic save, input logic [31:0] status,
                       input logic [31:0] cause, input int unsigned n, input logic use_ibus,
                       input commit_t exp_c, input logic [31:0] exp_pc);
      int unsigned t0, drain;
      redir_t r;
      @(posedge clk); #1;
      bus.exc_flag  = 1'b1;
      bus.exc_type  = t;
      bus.exc_pc    = pc;
      bus.exc_baddr = baddr;
      bus.exc_bd    = bd;
      bus.exc_save  = save;
      cp0_Status    = status;
      cp0_Cause     = cause;
      ibus_busy     = use_ibus && (n > 0);
      dbus_busy     = !use_ibus && (n > 0);
      @(negedge clk);
      t0 = cyc;
      chk("flush_at_T", 64'(flush), 64'd1);
      chk("stall_at_T", 64'(stall), 64'd0);
      drain     = (n == 0) ? 1 : n;
      exp_c.cyc = t0 + 1 + drain;
      cq.push_back(exp_c);
      r.cyc = t0 + 2 + drain;
      r.pc  = exp_pc;
      rq.push_back(r);
      for (int unsigned i = 1; i <= drain + 2; i++) begin
         @(posedge clk); #1;
         ibus_busy = use_ibus && (i < n);
         dbus_busy = !use_ibus && (i < n);
         // A competing request while busy must be ignored.
         bus.exc_flag  = (i < drain + 2);
         bus.exc_type  = EXCT_SYS;
         bus.exc_pc    = 32'hDEAD_0000;
         bus.exc_baddr = 32'hDEAD_0001;
         @(negedge clk);
         chk("seq_busy", 64'(seq_busy), 64'd1);
         chk("stall_seq", 64'(stall), 64'(i <= drain + 1));
         chk("flush_seq", 64'(flush), 64'(i == drain + 2));
      end
   endtask

   initial begin
      bus.exc_flag = 1'b0; bus.exc_type = '0; bus.exc_pc = '0; bus.exc_baddr = '0;
      bus.exc_bd = 1'b0; bus.exc_save = 1'b0;
      ibus_busy = 1'b0; dbus_busy = 1'b0;
      cp0_Status = '0; cp0_Cause = '0; cp0_EPC = 32'h8000_5000; cp0_ErrorEPC = 32'hBFC0_0380;
      #2 rst = 1'b1;
      #1;
      chk("rst_seq_busy", 64'(seq_busy), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_flush", 64'(flush), 64'd0);
      chk("rst_redir_en", 64'(redir_en), 64'd0);
      chk("rst_redir_pc", 64'(redir_pc), 64'd0);
      chk("rst_exc_we", 64'(bus.cp0_exc_we), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      send(EXCT_SYS, 32'h8000_1004, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0,
           mk(1, 5'd8, 1, 32'h8000_1004, 0, 0, 32'h0, 1, 0, 0), 32'h8000_0180);
      send(EXCT_TLBR, 32'h8000_1100, 32'h0040_3000, 1'b0, 1'b1, 32'h0, 32'h0, 5, 1'b0,
           mk(1, 5'd3, 1, 32'h8000_1100, 0, 1, 32'h0040_3000, 1, 0, 0), 32'h8000_0000);
      send(EXCT_ADEL, 32'h8000_2008, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0002, 32'h0, 2, 1'b1,
           mk(1, 5'd4, 0, 32'h0, 0, 1, 32'h0000_0003, 1, 0, 0), 32'h8000_0180);
      send(EXCT_ERET, 32'h8000_2100, 32'h0, 1'b0, 1'b0, 32'h0000_0004, 32'h0, 0, 1'b0,
           mk(0, 5'd0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 1), 32'hBFC0_0380);
      send(EXCT_ERET, 32'h8000_2200, 32'h0, 1'b0, 1'b0, 32'h0000_0002, 32'h0, 0, 1'b0,
           mk(0, 5'd0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0), 32'h8000_5000);
`ifdef EXC_SEQ_IV_EN
      send(EXCT_INTR, 32'h8000_3000, 32'h0, 1'b0, 1'b0, 32'h0040_0000, 32'h0080_0000, 0, 1'b0,
           mk(1, 5'd0, 1, 32'h8000_3000, 0, 0, 32'h0, 1, 0, 0), 32'hBFC0_0400);
`else
      send(EXCT_INTR, 32'h8000_3000, 32'h0, 1'b0, 1'b0, 32'h0040_0000, 32'h0080_0000, 0, 1'b0,
           mk(1, 5'd0, 1, 32'h8000_3000, 0, 0, 32'h0, 1, 0, 0), 32'hBFC0_0380);
`endif
      send(EXCT_TLBR, 32'h8000_3010, 32'h7FFF_F000, 1'b1, 1'b0, 32'h0040_0002, 32'h0, 1, 1'b0,
           mk(1, 5'd2, 0, 32'h0, 0, 1, 32'h7FFF_F000, 1, 0, 0), 32'hBFC0_0380);
      send(EXCT_OV, 32'h8000_4000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0,
           mk(1, 5'd12, 1, 32'h8000_4000, 0, 0, 32'h0, 1, 0, 0), 32'h8000_0180);
      send(EXCT_TLBM, 32'h8000_4004, 32'h0000_1000, 1'b1, 1'b1, 32'h0, 32'h0, 3, 1'b1,
           mk(1, 5'd1, 1, 32'h8000_4004, 1, 1, 32'h0000_1000, 1, 0, 0), 32'h8000_0180);

      // Abort mid-DRAIN: nothing may follow until the next request.
      @(posedge clk); #1;
      bus.exc_flag = 1'b1; bus.exc_type = EXCT_SYS; bus.exc_pc = 32'h8000_6000;
      cp0_Status = '0; dbus_busy = 1'b1;
      @(posedge clk); #1 bus.exc_flag = 1'b0;
      @(posedge clk); #3 rst = 1'b1;
      #1;
      chk("abort_seq_busy", 64'(seq_busy), 64'd0);
      chk("abort_stall", 64'(stall), 64'd0);
      chk("abort_flush", 64'(flush), 64'd0);
      chk("abort_redir_en", 64'(redir_en), 64'd0);
      chk("abort_epc_cleared", 64'(bus.cp0_epc), 64'd0);
      @(posedge clk); #1 rst = 1'b0; dbus_busy = 1'b0;
      repeat (6) @(posedge clk);

      send(EXCT_SYS, 32'h8000_7000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0,
           mk(1, 5'd8, 1, 32'h8000_7000, 0, 0, 32'h0, 1, 0, 0), 32'h8000_0180);

      repeat (4) @(posedge clk);
      chk("commit_queue_drained", 64'(cq.size()), 64'd0);
      chk("redir_queue_drained", 64'(rq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
